// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//
// Converts the neuron spike line into a rate code and the last inter-spike
// interval. A measurement starts on a start pulse in IDLE. It counts spike
// rising edges over win_len enabled cycles and then presents the result
// with a valid/ack handshake.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   ena        global enable; all registers hold while low
//   spike      spike line from the neuron (may stay high for several cycles)
//   start      one-cycle measurement request, honoured only in IDLE
//   win_len    window length in cycles, latched on an accepted start (0 = 2^WINDOW_W)
//   rate       spike edges counted in the last completed window (saturating)
//   isi        cycles between the last two edges of that window, 0 if fewer than two
//   rate_valid result available, held until rate_ack
//   rate_ack   consumer acknowledge
//   busy       high in COUNT and HOLD
//   sat        rate or isi saturated during the reported window
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; last result stays on rate/isi/sat
// COUNT  | measurement window running, window timer counts down
// HOLD   | result valid, waiting for rate_ack

module spike_rate_decoder #(
    parameter int WINDOW_W = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                spike,
    input  logic                start,
    input  logic [WINDOW_W-1:0] win_len,
    output logic [CNT_W-1:0]    rate,
    output logic [CNT_W-1:0]    isi,
    output logic                rate_valid,
    input  logic                rate_ack,
    output logic                busy,
    output logic                sat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // One extra bit so that a zero length can hold the full 2^WINDOW_W count.
    localparam logic [WINDOW_W:0] WIN_FULL = {1'b1, {WINDOW_W{1'b0}}};
    localparam logic [WINDOW_W:0] WIN_ONE  = {{WINDOW_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic                spike_q;
    logic [WINDOW_W:0]   win_cnt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    isi_run;
    logic [CNT_W-1:0]    isi_last;
    logic                have_edge;
    logic                sat_r;

    logic                spike_edge;
    logic                win_last;
    logic [WINDOW_W:0]   win_load;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    isi_run_nxt;
    logic [CNT_W-1:0]    isi_last_nxt;
    logic                sat_nxt;

    assign spike_edge = spike & ~spike_q;
    assign win_last   = (win_cnt == WIN_ONE);
    assign win_load   = (win_len == '0) ? WIN_FULL : {1'b0, win_len};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)    state_nxt = S_COUNT;
            S_COUNT: if (win_last) state_nxt = S_HOLD;
            S_HOLD:  if (rate_ack) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Output logic: the result is valid exactly while the FSM sits in HOLD.
    always_comb begin
        busy       = 1'b0;
        rate_valid = 1'b0;
        case (state)
            S_COUNT: busy = 1'b1;
            S_HOLD: begin
                busy       = 1'b1;
                rate_valid = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                rate_valid = 1'b0;
            end
        endcase
    end

    // Per-cycle update of the window accumulators. The clear of isi_run on an
    // edge takes priority over its increment.
    always_comb begin
        cnt_nxt      = cnt;
        isi_run_nxt  = isi_run;
        isi_last_nxt = isi_last;
        sat_nxt      = sat_r;
        if (have_edge && (isi_run != CNT_MAX)) begin
            isi_run_nxt = isi_run + CNT_ONE;
        end
        if (spike_edge) begin
            if (cnt == CNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
            if (have_edge) begin
                if (isi_run == CNT_MAX) begin
                    isi_last_nxt = CNT_MAX;
                    sat_nxt      = 1'b1;
                end else begin
                    isi_last_nxt = isi_run + CNT_ONE;
                end
                isi_run_nxt = '0;
            end
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q   <= 1'b0;
            win_cnt   <= '0;
            cnt       <= '0;
            isi_run   <= '0;
            isi_last  <= '0;
            have_edge <= 1'b0;
            sat_r     <= 1'b0;
            rate      <= '0;
            isi       <= '0;
            sat       <= 1'b0;
        end else if (ena) begin
            spike_q <= spike;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        win_cnt   <= win_load;
                        cnt       <= '0;
                        isi_run   <= '0;
                        isi_last  <= '0;
                        have_edge <= 1'b0;
                        sat_r     <= 1'b0;
                    end
                end
                S_COUNT: begin
                    win_cnt   <= win_cnt - WIN_ONE;
                    cnt       <= cnt_nxt;
                    isi_run   <= isi_run_nxt;
                    isi_last  <= isi_last_nxt;
                    have_edge <= have_edge | spike_edge;
                    sat_r     <= sat_nxt;
                    if (win_last) begin
                        rate <= cnt_nxt;
                        isi  <= isi_last_nxt;
                        sat  <= sat_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       spike;
    logic       start;
    logic [7:0] win_len;
    logic       rate_ack;

    logic [7:0] rate;
    logic [7:0] isi;
    logic       rate_valid;
    logic       busy;
    logic       sat;

    logic [3:0] rate4;
    logic [3:0] isi4;
    logic       rate_valid4;
    logic       busy4;
    logic       sat4;

    int n_pass  = 0;
    int n_total = 0;

    spike_rate_decoder #(.WINDOW_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .spike      (spike),
        .start      (start),
        .win_len    (win_len),
        .rate       (rate),
        .isi        (isi),
        .rate_valid (rate_valid),
        .rate_ack   (rate_ack),
        .busy       (busy),
        .sat        (sat)
    );

    spike_rate_decoder #(.WINDOW_W(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .spike      (spike),
        .start      (start),
        .win_len    (win_len),
        .rate       (rate4),
        .isi        (isi4),
        .rate_valid (rate_valid4),
        .rate_ack   (rate_ack),
        .busy       (busy4),
        .sat        (sat4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        win_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic do_ack();
        rate_ack = 1'b1;
        tick();
        rate_ack = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b1;
        spike    = 1'b0;
        start    = 1'b0;
        win_len  = 8'd0;
        rate_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rate",  rate, 0);
        chk("rst_isi",   isi, 0);
        chk("rst_valid", rate_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_sat",   sat, 0);

        // Basic window: spikes at cycles 2, 5, 9 of a 10-cycle window
        do_start(8'd10);
        chk("t1_busy_after_start", busy, 1);
        for (int c = 1; c <= 10; c++) begin
            spike = (c == 2 || c == 5 || c == 9);
            tick();
            if (c == 9) chk("t1_valid_not_early", rate_valid, 0);
        end
        spike = 1'b0;
        chk("t1_valid", rate_valid, 1);
        chk("t1_rate",  rate, 3);
        chk("t1_isi",   isi, 4);
        chk("t1_sat",   sat, 0);
        for (int c = 0; c < 4; c++) begin
            spike = c[0];
            tick();
        end
        spike = 1'b0;
        chk("t1_hold_valid", rate_valid, 1);
        chk("t1_hold_rate",  rate, 3);
        do_ack();
        chk("t1_ack_valid", rate_valid, 0);
        chk("t1_ack_busy",  busy, 0);
        chk("t1_keep_rate", rate, 3);
        chk("t1_keep_isi",  isi, 4);

        // Reset in the middle of a window
        do_start(8'd10);
        for (int c = 1; c <= 4; c++) begin
            spike = (c == 2);
            tick();
        end
        spike = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        chk("rst_mid_valid", rate_valid, 0);
        chk("rst_mid_busy",  busy, 0);
        chk("rst_mid_rate",  rate, 0);
        tick();
        chk("rst_mid_idle", busy, 0);
        do_start(8'd10);
        for (int c = 1; c <= 10; c++) begin
            spike = (c == 3 || c == 7);
            tick();
        end
        spike = 1'b0;
        chk("rst_fresh_valid", rate_valid, 1);
        chk("rst_fresh_rate",  rate, 2);
        chk("rst_fresh_isi",   isi, 4);
        do_ack();

        // Spike held high across the whole window counts once
        do_start(8'd8);
        for (int c = 1; c <= 8; c++) begin
            spike = 1'b1;
            tick();
        end
        spike = 1'b0;
        chk("held_valid", rate_valid, 1);
        chk("held_rate",  rate, 1);
        chk("held_isi",   isi, 0);
        do_ack();

        // 256-cycle window, spike toggling every cycle; 4-bit instance saturates
        do_start(8'd0);
        for (int c = 1; c <= 256; c++) begin
            spike = c[0];
            tick();
            if (c == 255) chk("full_valid_not_early", rate_valid, 0);
        end
        spike = 1'b0;
        chk("full_valid", rate_valid, 1);
        chk("full_rate",  rate, 128);
        chk("full_isi",   isi, 2);
        chk("full_sat",   sat, 0);
        chk("full_rate4", rate4, 15);
        chk("full_isi4",  isi4, 2);
        chk("full_sat4",  sat4, 1);
        do_ack();

        // start ignored in COUNT and HOLD; start+ack together returns to IDLE
        do_start(8'd10);
        for (int c = 1; c <= 10; c++) begin
            spike = (c == 1 || c == 4);
            start = (c == 5);
            if (c == 5) win_len = 8'd3;
            tick();
            if (c == 9) chk("ign_valid_not_early", rate_valid, 0);
        end
        spike = 1'b0;
        start = 1'b0;
        chk("ign_valid", rate_valid, 1);
        chk("ign_rate",  rate, 2);
        chk("ign_isi",   isi, 3);
        win_len = 8'd5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("ign_hold_valid", rate_valid, 1);
        chk("ign_hold_busy",  busy, 1);
        start    = 1'b1;
        rate_ack = 1'b1;
        tick();
        start    = 1'b0;
        rate_ack = 1'b0;
        chk("ackstart_valid", rate_valid, 0);
        chk("ackstart_busy",  busy, 0);
        tick();
        chk("ackstart_no_window", busy, 0);
        chk("ackstart_rate",      rate, 2);

        // ena low for three cycles inside a 6-cycle window
        do_start(8'd6);
        for (int c = 1; c <= 9; c++) begin
            ena   = !(c >= 3 && c <= 5);
            spike = (c == 1 || c == 4 || c == 7);
            tick();
            if (c == 8) chk("ena_valid_not_early", rate_valid, 0);
        end
        ena   = 1'b1;
        spike = 1'b0;
        chk("ena_valid", rate_valid, 1);
        chk("ena_rate",  rate, 2);
        chk("ena_isi",   isi, 3);
        do_ack();
        chk("ena_ack_valid", rate_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive-side counterpart to the neuron's spike output: converts the `spike` line from the STDP neuron core into a rate code and an inter-spike interval.
- Counts spike rising edges over a programmable measurement window and reports the count and the last inter-spike interval through a valid/ack handshake.
- Sits between the neuron's spike output and the readout path (uio/uo mux or host logic).

Parameters:
- WINDOW_W, 8, width of the window-length input; window = win_len cycles, win_len=0 treated as 2^WINDOW_W.
- CNT_W, 8, width of rate count and ISI outputs; both saturate at 2^CNT_W-1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ena  input  1  global enable; when low all registers hold, including FSM, counters and previous-spike register
- spike  input  1  spike line from neuron (may be high for several cycles)
- start  input  1  one-cycle request to begin a measurement; honoured only in IDLE
- win_len  input  WINDOW_W  window length in cycles, sampled on accepted start
- rate  output  CNT_W  spike edges counted in the last completed window
- isi  output  CNT_W  cycles between the last two spike edges in the window; 0 if fewer than two edges
- rate_valid  output  1  result available; held until acknowledged
- rate_ack  input  1  consumer acknowledge
- busy  output  1  high in COUNT and HOLD
- sat  output  1  rate or isi saturated during the reported window

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - State to IDLE.
  - rate=0, isi=0, rate_valid=0, busy=0, sat=0.
  - Internal counters and spike_q (previous spike) cleared to 0.
  - Reset overrides ena and every other input, including mid-window; a partial window is discarded.
- Edge detection:
  - edge = spike & ~spike_q, with spike_q registered every enabled cycle in every state.
  - A spike held high counts once.
  - A spike already high on the start cycle does not count unless it falls and rises again.
- FSM states: IDLE, COUNT, HOLD.
- IDLE:
  - busy=0.
  - On start=1 (with ena=1): latch win_len (0 -> 2^WINDOW_W), clear cnt, isi_run, isi_last, have_edge and sat_r.
  - Next state COUNT; busy=1 from the following cycle.
- COUNT: one window = exactly N enabled cycles, with N = latched length.
  - Every cycle: if have_edge, isi_run increments, saturating at max.
  - On edge:
    - cnt increments, saturating; if already at max, sat_r is set.
    - If have_edge, isi_last <= isi_run + 1 (saturating; sat_r set on saturation) and isi_run is cleared.
    - have_edge is set.
  - On the Nth cycle, edges in that cycle are still counted. Then: rate <= next cnt, isi <= next isi_last, sat <= next sat_r, rate_valid <= 1, state -> HOLD.
  - Latency: rate_valid rises N+1 cycles after the start cycle.
- HOLD:
  - Outputs stable; spikes ignored except for the spike_q update.
  - On rate_ack=1: rate_valid <= 0, state -> IDLE. rate, isi and sat keep their values until the next window completes.
  - start in HOLD is ignored.
- rate_ack outside HOLD has no effect.
- start during COUNT is ignored; win_len changes during COUNT are ignored.
- Simultaneous start and rate_ack in HOLD: ack takes effect and start is dropped. The consumer must reissue start in IDLE.
- ena=0: the cycle is not counted toward the window, edges are not detected, and the FSM does not advance.

Test Plan:
- rst mid-COUNT at cycle 5 of a 10-cycle window -> next cycle: rate_valid=0, busy=0, state IDLE; a following start with win_len=10 gives a fresh count.
- win_len=10, start, one-cycle spikes at cycles 2, 5, 9 after start -> rate_valid rises at cycle 11; rate=3, isi=4, sat=0; outputs held until rate_ack, rate_valid=0 the cycle after ack.
- win_len=8, spike held high for all 8 cycles starting cycle 1 -> rate=1, isi=0.
- win_len=0 (256-cycle window), spike toggling every cycle -> rate=128, isi=2; then CNT_W=4 build -> rate=15, sat=1.
- start during COUNT and during HOLD -> no restart, rate unchanged; start together with rate_ack in HOLD -> returns to IDLE, no new window.
- ena=0 for 3 cycles inside a 6-cycle window -> rate_valid at cycle 10 after start; a spike edge arriving only while ena=0 is not counted.
